md_unit: RTL and testbench



---
 rtl/md_unit.sv | 82 ++++++++
 tb/tb_md_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  HYLOOp,
    input  logic        valid,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    output logic        start,
    output logic        busy,
    output logic [31:0] hiloOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [31:0]        p_hi, p_lo;
    logic [3:0]         op;
    logic               is_md, is_mult, ovf, adj;
    logic [63:0]        s_prod, u_prod, res;
    logic [31:0]        ud, uq, ur;
    logic signed [31:0] sd, sq, sr, fq, fr;
    assign op      = valid ? HYLOOp : 4'd0;
    assign is_mult = op == 4'd1 || op == 4'd2;
    assign is_md   = is_mult || op == 4'd3 || op == 4'd4 || op == 4'd9;
    assign busy    = state == RUN;
    assign start   = is_md && !busy;
    assign hiloOut = op == 4'd5 ? hi : lo;
    // result of the op presented this cycle; divide-by-zero keeps the committed HI/LO
    always_comb begin
        s_prod = {{32{rsData[31]}}, rsData} * {{32{rtData[31]}}, rtData};
        u_prod = {32'd0, rsData} * {32'd0, rtData};
        ovf    = rsData == 32'h8000_0000 && rtData == 32'hFFFF_FFFF;
        ud     = rtData == 32'd0 ? 32'd1 : rtData;
        sd     = (rtData == 32'd0 || ovf) ? 32'sd1 : $signed(rtData);
        uq     = rsData / ud;
        ur     = rsData % ud;
        sq     = $signed(rsData) / sd;
        sr     = $signed(rsData) % sd;
        adj    = sr != 32'sd0 && (sr[31] ^ rtData[31]);
        fq     = adj ? sq - 32'sd1 : sq;
        fr     = adj ? sr + $signed(rtData) : sr;
        res    = op == 4'd1 ? s_prod :
                 op == 4'd2 ? u_prod :
                 rtData == 32'd0 ? {hi, lo} :
                 (ovf && op != 4'd4) ? {32'd0, 32'h8000_0000} :
                 op == 4'd3 ? {sr, sq} :
                 op == 4'd4 ? {ur, uq} : {fr, fq};
    end
    // IDLE/RUN sequencer: latch pending result on start, commit when the count expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                p_hi  <= res[63:32];
                p_lo  <= res[31:0];
                cnt   <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                state <= RUN;
            end else if (op == 4'd7) hi <= rsData;
            else if (op == 4'd8) lo <= rsData;
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi    <= p_hi;
                lo    <= p_lo;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit
module tb_md_unit;
    logic        clk = 0, reset = 1, valid = 0, start, busy;
    logic [3:0]  HYLOOp = 0;
    logic [31:0] rsData = 0, rtData = 0, hiloOut, hi, lo;
    logic [63:0] sb[$];
    logic [63:0] e;
    int          nvec = 0, nfail = 0, n;

    md_unit dut (.clk(clk), .reset(reset), .HYLOOp(HYLOOp), .valid(valid), .rsData(rsData),
                 .rtData(rtData), .start(start), .busy(busy), .hiloOut(hiloOut), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        HYLOOp = o; valid = v; rsData = a; rtData = b;
        #1;
    endtask

    task automatic wait_done(input string tag, input int from, input int exp_n);
        n = from;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(exp_n));
        e = sb.pop_front();
        chk({tag, " hi"}, hi, e[63:32]);
        chk({tag, " lo"}, lo, e[31:0]);
        chk({tag, " hiloOut"}, hiloOut, e[31:0]);
    endtask

    task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int cyc);
        drive(o, 1, a, b);
        chk({tag, " start"}, 32'(start), 1);
        sb.push_back({eh, el});
        drive(0, 0, 0, 0);
        wait_done(tag, 0, cyc);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset hiloOut", hiloOut, 0);
        chk("reset start", 32'(start), 0);
        @(negedge clk);
        reset = 0;
        run_md("mult", 1, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_md("multu", 2, 32'hFFFF_FFFE, 3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        run_md("div", 3, -32'sd7, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_md("fdiv", 9, -32'sd7, 2, 32'h0000_0001, 32'hFFFF_FFFC, 10);
        run_md("fdiv neg divisor", 9, 7, -32'sd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 10);
        run_md("fdiv exact", 9, -32'sd8, 2, 0, 32'hFFFF_FFFC, 10);
        run_md("divu", 4, 7, 2, 1, 3, 10);
        run_md("div ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 10);
        run_md("fdiv ovf", 9, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 10);
        drive(7, 1, 32'h11, 0);
        drive(8, 1, 32'h22, 0);
        run_md("divu by 0", 4, 9, 0, 32'h11, 32'h22, 10);
        drive(7, 1, 32'hDEAD_BEEF, 0);
        drive(5, 1, 0, 0);
        chk("mfhi", hiloOut, 32'hDEAD_BEEF);
        drive(8, 1, 5, 0);
        drive(6, 1, 0, 0);
        chk("mflo", hiloOut, 5);
        drive(1, 0, 6, 7);
        chk("invalid mult start", 32'(start), 0);
        drive(0, 0, 0, 0);
        chk("invalid mult busy", 32'(busy), 0);
        chk("invalid mult hi", hi, 32'hDEAD_BEEF);
        chk("invalid mult lo", lo, 5);
        drive(1, 1, 6, 7);
        sb.push_back({32'd0, 32'd42});
        drive(7, 1, 32'h1234, 0);
        chk("mthi while busy start", 32'(start), 0);
        drive(1, 1, 100, 100);
        chk("mult while busy start", 32'(start), 0);
        drive(0, 0, 0, 0);
        wait_done("ignored ops", 2, 5);
        repeat (12) @(negedge clk);
        #1;
        chk("no late write lo", lo, 42);
        drive(3, 1, 100, 7);
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("div busy before reset", 32'(busy), 1);
        reset = 1;
        #1;
        chk("async reset busy", 32'(busy), 0);
        chk("async reset hi", hi, 0);
        chk("async reset lo", lo, 0);
        @(negedge clk);
        reset = 0;
        repeat (15) @(negedge clk);
        #1;
        chk("post reset busy", 32'(busy), 0);
        chk("post reset hi", hi, 0);
        chk("post reset lo", lo, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
